// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: pin filtering, frame deserialisation, E0/F0 prefix folding
module ps2_scancode_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       key_release,
    output logic       key_extended,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_f_q, clk_f_d, dat_f_q, dat_f_d;
    logic [FW-1:0] clk_fcnt_q, clk_fcnt_d, dat_fcnt_q, dat_fcnt_d;
    logic          clk_prev_q;
    logic          fall;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    shreg_q, shreg_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [7:0]    keycode_q, keycode_d;
    logic          key_valid_q, key_valid_d, key_release_q, key_release_d;
    logic          key_extended_q, key_extended_d, frame_err_q, frame_err_d;

    // A filtered line only flips after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        clk_f_d    = clk_f_q;
        clk_fcnt_d = '0;
        if (clk_s2_q != clk_f_q) begin
            if (clk_fcnt_q == FW'(FILTER_LEN - 1)) clk_f_d = clk_s2_q;
            else clk_fcnt_d = clk_fcnt_q + 1'b1;
        end
        dat_f_d    = dat_f_q;
        dat_fcnt_d = '0;
        if (dat_s2_q != dat_f_q) begin
            if (dat_fcnt_q == FW'(FILTER_LEN - 1)) dat_f_d = dat_s2_q;
            else dat_fcnt_d = dat_fcnt_q + 1'b1;
        end
    end

    assign fall = clk_prev_q & ~clk_f_q;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        to_cnt_d       = to_cnt_q;
        ext_pend_d     = ext_pend_q;
        brk_pend_d     = brk_pend_q;
        keycode_d      = keycode_q;
        key_release_d  = key_release_q;
        key_extended_d = key_extended_q;
        key_valid_d    = 1'b0;
        frame_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (fall && !dat_f_q) begin
                    state_d   = S_RECV;
                    bit_cnt_d = 4'd0;
                end
            end
            S_RECV: begin
                if (fall) begin
                    // Bits enter at the top so the stop bit ends in [9], parity in [8].
                    shreg_d   = {dat_f_q, shreg_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == 4'd9) state_d = S_DONE;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d     = S_IDLE;
                    to_cnt_d    = '0;
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if ((^shreg_q[8:0]) && shreg_q[9]) begin
                    if (shreg_q[7:0] == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (shreg_q[7:0] == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        keycode_d      = shreg_q[7:0];
                        key_extended_d = ext_pend_q;
                        key_release_d  = brk_pend_q;
                        key_valid_d    = 1'b1;
                        ext_pend_d     = 1'b0;
                        brk_pend_d     = 1'b0;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    ext_pend_d  = 1'b0;
                    brk_pend_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q       <= 1'b1;
            clk_s2_q       <= 1'b1;
            dat_s1_q       <= 1'b1;
            dat_s2_q       <= 1'b1;
            clk_f_q        <= 1'b1;
            dat_f_q        <= 1'b1;
            clk_fcnt_q     <= '0;
            dat_fcnt_q     <= '0;
            clk_prev_q     <= 1'b1;
            state_q        <= S_IDLE;
            bit_cnt_q      <= 4'd0;
            shreg_q        <= '0;
            to_cnt_q       <= '0;
            ext_pend_q     <= 1'b0;
            brk_pend_q     <= 1'b0;
            keycode_q      <= 8'h00;
            key_valid_q    <= 1'b0;
            key_release_q  <= 1'b0;
            key_extended_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            clk_s1_q       <= ps2_clk;
            clk_s2_q       <= clk_s1_q;
            dat_s1_q       <= ps2_data;
            dat_s2_q       <= dat_s1_q;
            clk_f_q        <= clk_f_d;
            dat_f_q        <= dat_f_d;
            clk_fcnt_q     <= clk_fcnt_d;
            dat_fcnt_q     <= dat_fcnt_d;
            clk_prev_q     <= clk_f_q;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            to_cnt_q       <= to_cnt_d;
            ext_pend_q     <= ext_pend_d;
            brk_pend_q     <= brk_pend_d;
            keycode_q      <= keycode_d;
            key_valid_q    <= key_valid_d;
            key_release_q  <= key_release_d;
            key_extended_q <= key_extended_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign keycode      = keycode_q;
    assign key_valid    = key_valid_q;
    assign key_release  = key_release_q;
    assign key_extended = key_extended_q;
    assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx
module tb_ps2_scancode_rx;
    localparam int FL = 8;
    localparam int TO = 400;
    localparam int H  = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_valid, key_release, key_extended, frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_cyc = -1;
    int last_fall_cyc = 0;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;
    ev_t exp_q[$];
    logic [7:0] m_code = 8'h00;
    logic       m_rel = 1'b0;
    logic       m_ext = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .key_valid(key_valid), .key_release(key_release),
        .key_extended(key_extended), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_valid || frame_err)) begin
            ev_t e;
            chk("valid_err_exclusive", {31'd0, key_valid && frame_err}, 32'd0);
            if (frame_err) err_cyc = cyc;
            chk("event_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("event_fields", 32'({frame_err, keycode, key_release, key_extended}), 32'(e));
            end
        end
    end

    task automatic expect_key(input logic [7:0] c, input logic r, input logic x);
        m_code = c; m_rel = r; m_ext = x;
        exp_q.push_back({1'b0, c, r, x});
    endtask

    task automatic expect_err();
        exp_q.push_back({1'b1, m_code, m_rel, m_ext});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2_data = fr[i];
            repeat (H / 2) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
            if (glitch) begin
                repeat (15) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (H - 18) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
    endtask

    task automatic gap_and_drain(input string tag);
        @(negedge clk) ps2_data = 1'b1;
        ps2_clk = 1'b1;
        repeat (150) @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_outputs", 32'({keycode, key_valid, key_release, key_extended, frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 0, 11);
        gap_and_drain("drain_1c");

        send_frame(8'hF0, 0, 0, 0, 11);
        gap_and_drain("drain_f0_no_pulse");
        expect_key(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C, 0, 0, 0, 11);
        gap_and_drain("drain_break_1c");

        send_frame(8'hE0, 0, 0, 0, 11);
        send_frame(8'hF0, 0, 0, 0, 11);
        gap_and_drain("drain_e0_f0");
        expect_key(8'h74, 1'b1, 1'b1);
        send_frame(8'h74, 0, 0, 0, 11);
        gap_and_drain("drain_ext_break_74");
        expect_key(8'h74, 1'b0, 1'b0);
        send_frame(8'h74, 0, 0, 0, 11);
        gap_and_drain("drain_plain_74");

        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 0, 11);
        expect_err();
        send_frame(8'h2A, 1, 0, 0, 11);
        gap_and_drain("drain_parity_err");
        expect_err();
        send_frame(8'hF0, 0, 1, 0, 11);
        expect_key(8'h32, 1'b0, 1'b0);
        send_frame(8'h32, 0, 0, 0, 11);
        gap_and_drain("drain_stop_err_32");

        err_cyc = -1;
        expect_err();
        send_frame(8'h05, 0, 0, 0, 5);
        @(negedge clk) ps2_data = 1'b1;
        repeat (TO + 60) @(negedge clk);
        chk("timeout_fired", {31'd0, err_cyc >= 0}, 32'd1);
        chk("timeout_latency",
            {31'd0, (err_cyc - last_fall_cyc >= TO + FL + 1) && (err_cyc - last_fall_cyc <= TO + FL + 5)},
            32'd1);
        gap_and_drain("drain_timeout");
        expect_key(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 0, 0, 0, 11);
        gap_and_drain("drain_after_timeout_5a");

        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 0, 0, 1, 11);
        gap_and_drain("drain_glitch_1c");

        send_frame(8'h55, 0, 0, 0, 6);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            32'({keycode, key_valid, key_release, key_extended, frame_err}), 32'd0);
        m_code = 8'h00; m_rel = 1'b0; m_ext = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_reset_quiet", 32'({keycode, key_valid, frame_err}), 32'd0);
        expect_key(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 0, 0, 0, 11);
        gap_and_drain("drain_after_reset_29");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receive front end that drives the keycode path into the sender's display and UART logic. It synchronises and deglitches the raw `PS2Clk`/`PS2Data` pins and deserialises 11-bit device-to-host frames. It checks parity and stop bit and folds the `E0` (extended) and `F0` (break) prefix bytes into flags, so downstream logic sees one `key_valid` pulse per complete key event. It runs entirely in the 100 MHz system clock domain; the PS/2 clock is sampled, never used as a clock.

## Interface
- `FILTER_LEN`, 8: system cycles a synchronised PS/2 line must hold a new level before the filtered copy changes (≥2).
- `TIMEOUT`, 100000: idle cycles allowed between filtered falling edges inside a frame before abort (1 ms at 100 MHz).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `keycode`  out  8  last decoded scan code; holds between events.
- `key_valid`  out  1  one-cycle pulse when `keycode` and the flags update.
- `key_release`  out  1  event was preceded by `F0`.
- `key_extended`  out  1  event was preceded by `E0`.
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Input path per line: 2-flop synchroniser, then a filter counter. The filtered level flips only after the synchronised level differs from it for `FILTER_LEN` consecutive cycles. The counter clears whenever they agree.
- `fall` is a one-cycle strobe when filtered clock goes 1→0. Filtered data is sampled in that cycle.
- FSM states: IDLE, RECV, DONE.
  - IDLE: on `fall` with data 0 (start bit), go to RECV and set bit_cnt=0. On `fall` with data 1, stay in IDLE and raise no error.
  - RECV: on each `fall`, shift data in LSB first. bit_cnt 0–7 are data, 8 is parity, 9 is stop. After the stop bit, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Timeout counter clears on every `fall` and counts in RECV only. When it reaches `TIMEOUT`, the FSM goes to IDLE, pulses `frame_err` and clears both pending flags.
- DONE check: the frame is good if parity is odd (XOR of 8 data bits and parity bit = 1) and stop = 1. Otherwise pulse `frame_err`, clear pending flags and leave `keycode` unchanged.
- Good byte handling:
  - `E0`: set ext_pending, no output.
  - `F0`: set brk_pending, no output.
  - Any other byte:
    - load `keycode`=byte, `key_extended`=ext_pending, `key_release`=brk_pending;
    - pulse `key_valid`;
    - clear both pending flags.
- Repeated prefixes (`E0 E0`, `F0 F0`) just keep the flag set.

## Timing
- Reset values: `keycode`=0x00, `key_valid`=0, `key_release`=0, `key_extended`=0, `frame_err`=0. Filtered lines and synchronisers reset to 1, FSM to IDLE, counters and pending flags to 0.
- Raw pin edge to filtered edge: 2 + `FILTER_LEN` cycles, exactly, for a clean edge.
- The stop-bit `fall` happens in cycle t, DONE is in t+1, and `key_valid`/`frame_err` and the updated outputs are registered at the end of t+1.
  - `key_valid`/`frame_err` are high for cycle t+2 only.
  - `keycode`, `key_release` and `key_extended` change at the same edge and then hold.
- `key_valid` and `frame_err` are never high in the same cycle.
- Reset mid-frame aborts immediately. There is no partial output, and the next frame starting with a clean start bit decodes normally.
- Timeout and `fall` in the same cycle: `fall` wins and the counter clears.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles never produce `fall`.

## Test plan
- Reset, then send frame `1C` at 10 kHz PS/2 clock → one `key_valid` pulse, `keycode`=0x1C, release=0, extended=0, `frame_err` never high.
- Send `F0`, `1C` → single `key_valid` pulse after the second frame, `keycode`=0x1C, release=1, extended=0. No pulse after `F0`.
- Send `E0`, `F0`, `74` → one pulse, `keycode`=0x74, release=1, extended=1. Then send `74` alone → release=0, extended=0.
- Send `1C`, then `2A` with the parity bit flipped → one `frame_err` pulse and no `key_valid`; `keycode` stays 0x1C. Then `F0` with stop bit 0, then `32` → `frame_err`, then a `key_valid` pulse with release=0, extended=0, `keycode`=0x32.
- Send start + 4 data bits, then stop toggling → `frame_err` exactly `TIMEOUT` cycles after the last `fall`. A following good `5A` frame decodes to 0x5A.
- Inject 3-cycle low glitches on `ps2_clk` during a `1C` frame (`FILTER_LEN`=8) → still decodes 0x1C. Assert `rst_n`=0 mid-frame → all outputs 0 immediately and the next frame decodes correctly.
